// File: rtl/dff_pipe.sv
// dff_pipe: stallable, flushable WIDTH x DEPTH register delay line.
// Carries a valid flag alongside every data stage and keeps a registered
// count of how many stages currently hold valid words. Bubbles are written
// as RST_VAL so that idle stages never carry stale data downstream.
module dff_pipe #(
    parameter int                WIDTH   = 8,
    parameter int                DEPTH   = 4,
    parameter logic [WIDTH-1:0]  RST_VAL = '0,
    localparam int               OCC_W   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic              clr,
    input  logic [WIDTH-1:0]  d,
    input  logic              vld_in,
    output logic [WIDTH-1:0]  q,
    output logic              vld_out,
    output logic [OCC_W-1:0]  occ
);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;

    // Next-state: clear beats advance, advance beats hold.
    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        occ_d  = occ_q;
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_d[i] = RST_VAL;
            end
            vld_d = '0;
            occ_d = '0;
        end else if (en) begin
            data_d[0] = vld_in ? d : RST_VAL;
            vld_d[0]  = vld_in;
            for (int i = 1; i < DEPTH; i++) begin
                data_d[i] = data_q[i-1];
                vld_d[i]  = vld_q[i-1];
            end
            // Entering and leaving words cancel; only the unbalanced cases move occ.
            case ({vld_in, vld_q[DEPTH-1]})
                2'b10:   occ_d = occ_q + OCC_W'(1);
                2'b01:   occ_d = occ_q - OCC_W'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    // State registers; reset empties every stage without waiting for a clock.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= RST_VAL;
            end
            vld_q <= '0;
            occ_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
            end
            vld_q <= vld_d;
            occ_q <= occ_d;
        end
    end

    assign q       = data_q[DEPTH-1];
    assign vld_out = vld_q[DEPTH-1];
    assign occ     = occ_q;

endmodule

// File: tb/tb_dff_pipe.sv
// Bench for dff_pipe: four instances (DEPTH 4/1/4/7) share one stimulus
// stream; a queue scoreboard per instance predicts q, vld_out and occ.
module tb_dff_pipe;

    logic       clk    = 1'b0;
    logic       rstn   = 1'b1;
    logic       en     = 1'b0;
    logic       clr    = 1'b0;
    logic       vld_in = 1'b0;
    logic [7:0] d      = 8'h00;

    logic [7:0] q0, q1, q2, q3;
    logic       v0, v1, v2, v3;
    logic [2:0] o0;
    logic       o1;
    logic [2:0] o2;
    logic [2:0] o3;

    dff_pipe #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'h00)) u0 (
        .clk(clk), .rstn(rstn), .en(en), .clr(clr), .d(d), .vld_in(vld_in),
        .q(q0), .vld_out(v0), .occ(o0));
    dff_pipe #(.WIDTH(8), .DEPTH(1), .RST_VAL(8'h5A)) u1 (
        .clk(clk), .rstn(rstn), .en(en), .clr(clr), .d(d), .vld_in(vld_in),
        .q(q1), .vld_out(v1), .occ(o1));
    dff_pipe #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'h5A)) u2 (
        .clk(clk), .rstn(rstn), .en(en), .clr(clr), .d(d), .vld_in(vld_in),
        .q(q2), .vld_out(v2), .occ(o2));
    dff_pipe #(.WIDTH(8), .DEPTH(7), .RST_VAL(8'h5A)) u3 (
        .clk(clk), .rstn(rstn), .en(en), .clr(clr), .d(d), .vld_in(vld_in),
        .q(q3), .vld_out(v3), .occ(o3));

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         due;
    } ent_t;

    localparam int         DEP [4] = '{4, 1, 4, 7};
    localparam logic [7:0] RV  [4] = '{8'h00, 8'h5A, 8'h5A, 8'h5A};

    int         total = 0;
    int         bad   = 0;
    int         adv_cnt = 0;
    ent_t       sbq [4][$];
    bit         held_v [4];
    logic [7:0] held_d [4];
    ent_t       ent;
    logic [7:0] qa [4];
    logic       va [4];
    int         oa [4];
    int         pc [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 4; i++) begin
            sbq[i].delete();
            held_v[i] = 1'b0;
        end
    endfunction

    // Drive one edge; the model learns what that edge did once it has passed.
    task automatic step(input bit e, input bit c, input bit v, input logic [7:0] dv);
        en = e; clr = c; vld_in = v; d = dv;
        @(posedge clk);
        #1;
        if (!rstn || c) begin
            model_clear();
        end else if (e) begin
            adv_cnt++;
            for (int i = 0; i < 4; i++) begin
                held_v[i] = 1'b0;
                if (v) begin
                    ent.data = dv;
                    ent.due  = adv_cnt + DEP[i] - 1;
                    sbq[i].push_back(ent);
                end
            end
        end
    endtask

    // Monitor: pops a word when its due advance count arrives, then compares outputs.
    always @(negedge clk) begin
        qa = '{q0, q1, q2, q3};
        va = '{v0, v1, v2, v3};
        oa = '{int'(o0), int'(o1), int'(o2), int'(o3)};
        pc = '{$countones(u0.vld_q), $countones(u1.vld_q),
               $countones(u2.vld_q), $countones(u3.vld_q)};
        for (int i = 0; i < 4; i++) begin
            if (sbq[i].size() > 0 && sbq[i][0].due == adv_cnt) begin
                ent = sbq[i].pop_front();
                held_d[i] = ent.data;
                held_v[i] = 1'b1;
            end
            check($sformatf("mon_vld%0d", i), 32'(va[i]), 32'(held_v[i]));
            check($sformatf("mon_q%0d", i), 32'(qa[i]), 32'(held_v[i] ? held_d[i] : RV[i]));
            check($sformatf("mon_occ%0d", i), oa[i], sbq[i].size() + int'(held_v[i]));
            check($sformatf("popcount%0d", i), pc[i], oa[i]);
        end
    end

    int         exp_occ2 [11] = '{1, 2, 3, 4, 4, 3, 2, 1, 0, 0, 0};
    logic [7:0] d4   [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00};
    bit         vi4  [8] = '{1, 0, 1, 0, 0, 0, 0, 0};
    int         eo4  [8] = '{1, 1, 2, 2, 1, 1, 0, 0};
    bit         ev4  [8] = '{0, 0, 0, 1, 0, 1, 0, 0};
    logic [7:0] eq4  [8] = '{8'h00, 8'h00, 8'h00, 8'h11, 8'h00, 8'h33, 8'h00, 8'h00};

    initial begin
        #1 rstn = 1'b0;

        // reset held with active inputs
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b0, 1'b1, 8'hFF);
            check("rst_q", q0, 8'h00);
            check("rst_vld", v0, 0);
            check("rst_occ", o0, 0);
            check("rst_q_5a", q3, 8'h5A);
        end
        rstn = 1'b1;

        // asynchronous reset mid-stream
        step(1'b1, 1'b0, 1'b1, 8'h01);
        step(1'b1, 1'b0, 1'b1, 8'h02);
        step(1'b1, 1'b0, 1'b1, 8'h03);
        #2;
        check("pre_async_occ", o0, 3);
        rstn = 1'b0;
        model_clear();
        #1;
        check("async_q", q0, 8'h00);
        check("async_vld", v0, 0);
        check("async_occ", o0, 0);
        check("async_occ7", o3, 0);
        check("async_q7", q3, 8'h5A);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        rstn = 1'b1;

        // latency and ordering
        for (int k = 0; k < 11; k++) begin
            step(1'b1, 1'b0, (k < 5), (k < 5) ? 8'(k + 1) : 8'h00);
            check("lat_occ", o0, exp_occ2[k]);
            check("lat_vld", v0, (k >= 3 && k <= 7) ? 1 : 0);
            check("lat_q", q0, (k >= 3 && k <= 7) ? (k - 2) : 0);
        end

        // stall
        step(1'b1, 1'b0, 1'b1, 8'hA1);
        step(1'b1, 1'b0, 1'b1, 8'hA2);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 1'b1, 8'(8'hC0 + k));
            check("stall_occ", o0, 2);
            check("stall_vld", v0, 0);
            check("stall_q", q0, 8'h00);
        end
        step(1'b1, 1'b0, 1'b0, 8'h00);
        check("stall_e6_vld", v0, 0);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        check("stall_e7_vld", v0, 1);
        check("stall_e7_q", q0, 8'hA1);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        check("stall_e8_q", q0, 8'hA2);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        check("stall_e9_vld", v0, 0);
        check("stall_e9_occ", o0, 0);

        // bubbles
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b0, vi4[k], d4[k]);
            check("bub_occ", o0, eo4[k]);
            check("bub_vld", v0, ev4[k]);
            check("bub_q", q0, eq4[k]);
        end

        // flush with a competing input word
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0, 1'b1, 8'(8'hB1 + k));
        end
        check("pre_flush_occ", o0, 4);
        step(1'b1, 1'b1, 1'b1, 8'h77);
        check("flush_occ", o0, 0);
        check("flush_vld", v0, 0);
        check("flush_q", q0, 8'h00);
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 1'b0, 1'b0, 8'h00);
            check("post_flush_vld", v0, 0);
        end

        // random regression against the queue model
        for (int k = 0; k < 2000; k++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0,
                 $urandom_range(0, 1) == 1, 8'($urandom_range(0, 255)));
        end
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b0, 1'b0, 8'h00);
        end

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
